bip39_entropy_packer: RTL and testbench
=======================================

// Module: bip39_entropy_packer
// PURPOSE
//  Downstream of the 8-bit random generator. Samples its byte stream, packs the bits MSB-first into
//  11-bit BIP39 word indices (0..2047) and buffers them in a FWFT FIFO for Nios PIO/mnemonic logic.
//  Sampling throttles itself when the FIFO is full; no entropy bits are dropped or reused.
// PARAMETERS
//  SAMPLE_DIV  4   clocks between generator samples (>=1); decorrelates successive LFSR bytes
//  FIFO_DEPTH  16  index FIFO depth, power of two, >=2
//  RCT_CUTOFF  8   repetition-count cutoff (used only when BIP39_RCT_EN defined), >=2
// PORTS
//  i_clk        in   1   system clock (CLOCK_50 domain)
//  i_reset_n    in   1   asynchronous active-low reset
//  i_enable     in   1   1 = sample and pack; 0 = idle, accumulator cleared, FIFO kept
//  i_flush      in   1   sync clear of FIFO, accumulator, FSM and health flag
//  i_random     in   8   byte from random generator o_data
//  i_rd         in   1   pop strobe; honoured only when o_valid=1
//  o_index      out  11  FIFO head word index (valid while o_valid)
//  o_valid      out  1   FIFO not empty
//  o_level      out  $clog2(FIFO_DEPTH)+1  words held
//  o_health_fail out 1   sticky repetition-test failure (0 without BIP39_RCT_EN)
// BEHAVIOUR
//  Reset: FSM=S_IDLE, acc=0 (18b), bit_cnt=0 (5b), div_cnt=0, FIFO empty; o_index=0, o_valid=0,
//   o_level=0, o_health_fail=0.
//  FSM (one transition per clock):
//   S_IDLE : i_enable=1 -> S_WAIT with div_cnt=SAMPLE_DIV-1.
//   S_WAIT : div_cnt==0 -> S_LOAD, else div_cnt--.
//   S_LOAD : acc<=(acc<<8)|i_random, bit_cnt+=8 -> S_EMIT.
//   S_EMIT : bit_cnt<11 -> S_WAIT (reload div_cnt). bit_cnt>=11 and FIFO not full -> push
//            acc[bit_cnt-1 -: 11], bit_cnt-=11, -> S_WAIT. bit_cnt>=11 and full -> hold in S_EMIT.
//  bit_cnt never exceeds 18 (max 10 leftover + 8); at most one push per S_EMIT; bits above bit_cnt
//   are don't-care and must not reach o_index.
//  i_enable=0 in any state -> S_IDLE next clock, acc/bit_cnt cleared, partial bits discarded.
//  i_flush has priority over everything incl. enable; takes effect next clock; FIFO empty after.
//  FIFO: FWFT, o_index=head combinationally from storage; push/pop pointers wrap modulo FIFO_DEPTH.
//   Full evaluated before same-cycle pop: push while full is refused even if i_rd=1 that cycle.
//   Simultaneous push+pop when not full/not empty: o_level unchanged. i_rd while empty ignored.
//  Latency: byte captured in S_LOAD appears on o_index (when completing a word) 2 clocks later.
// CONFIGURATION
//  BIP39_RCT_EN defined: 8-bit repeat counter compares each S_LOAD byte to previous sampled byte;
//   equal -> count++, else count=1. count reaching RCT_CUTOFF sets o_health_fail (sticky until
//   flush/reset); while set, S_LOAD does not append (bit_cnt unchanged) and no further pushes occur.
//  BIP39_RCT_EN undefined: no counter logic, o_health_fail tied 0, RCT_CUTOFF ignored.
// TESTING
//  1 SAMPLE_DIV=1, enable, bytes A5,3C -> one push, o_index=0x529, bit_cnt=5, o_valid 2 clk after 2nd S_LOAD.
//  2 continue with byte FF -> o_index second word 0x73F, bit_cnt=2; pops return 0x529 then 0x73F.
//  3 never pop, constant stream -> o_level stops at FIFO_DEPTH, FSM holds S_EMIT, no word lost:
//    after one pop exactly one push, sequence continuous with golden bit-packing model.
//  4 full FIFO, i_rd=1 in cycle of pending push -> push refused, o_level=FIFO_DEPTH-1, push next clk.
//  5 drop i_enable mid-word (bit_cnt=8), re-enable -> old 8 bits discarded; i_flush -> o_level=0.
//  6 BIP39_RCT_EN, RCT_CUTOFF=8, i_random held 0x00 -> o_health_fail=1 on 8th sample, no more pushes;
//    without macro same stimulus -> packs 0x000 words, o_health_fail stays 0.

Source files
------------

// File: rtl/bip39_entropy_packer.sv
// bip39_entropy_packer: samples the random generator byte stream, packs bits
// MSB-first into 11-bit BIP39 word indices and buffers them in a FWFT FIFO.
// Optional repetition-count health test enabled by defining BIP39_RCT_EN.
module bip39_entropy_packer #(
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned RCT_CUTOFF = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_enable,
    input  logic                        i_flush,
    input  logic [7:0]                  i_random,
    input  logic                        i_rd,
    output logic [10:0]                 o_index,
    output logic                        o_valid,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_health_fail
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DW-1:0] DIV_RELOAD = DW'(SAMPLE_DIV - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD, S_EMIT} state_t;

    state_t          state_q, state_d;
    logic [17:0]     acc_q, acc_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [10:0]     mem_q [FIFO_DEPTH];

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [17:0]     acc_shift;
    logic [10:0]     word;
    logic            health;

`ifdef BIP39_RCT_EN
    logic [7:0] prev_q, prev_d;
    logic [7:0] rct_cnt_q, rct_cnt_d;
    logic       health_q, health_d;

    // Repetition count over sampled bytes; failure flag is sticky until flush/reset
    always_comb begin
        prev_d    = prev_q;
        rct_cnt_d = rct_cnt_q;
        health_d  = health_q;
        if (i_flush) begin
            prev_d    = '0;
            rct_cnt_d = '0;
            health_d  = 1'b0;
        end else if (i_enable && state_q == S_LOAD) begin
            prev_d = i_random;
            if (rct_cnt_q != 8'd0 && i_random == prev_q) begin
                rct_cnt_d = (rct_cnt_q == 8'hFF) ? rct_cnt_q : rct_cnt_q + 8'd1;
            end else begin
                rct_cnt_d = 8'd1;
            end
            if (rct_cnt_d >= 8'(RCT_CUTOFF)) begin
                health_d = 1'b1;
            end
        end
    end

    // Health test registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prev_q    <= '0;
            rct_cnt_q <= '0;
            health_q  <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            rct_cnt_q <= rct_cnt_d;
            health_q  <= health_d;
        end
    end

    assign health = health_q;
`else
    assign health = 1'b0;
`endif

    assign fifo_full  = (level_q == FULL_LEVEL);
    assign fifo_empty = (level_q == '0);
    // Extract the 11 bits just below bit_cnt so stale upper bits never leak out
    assign acc_shift  = acc_q >> (bit_cnt_q - 5'd11);
    assign word       = acc_shift[10:0];

    // Sampling/packing FSM: next state, accumulator and push request
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        push      = 1'b0;
        if (i_flush || !i_enable) begin
            state_d   = S_IDLE;
            acc_d     = '0;
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_WAIT;
                    div_cnt_d = DIV_RELOAD;
                end
                S_WAIT: begin
                    if (div_cnt_q == '0) begin
                        state_d = S_LOAD;
                    end else begin
                        div_cnt_d = div_cnt_q - DW'(1);
                    end
                end
                S_LOAD: begin
                    if (!health) begin
                        acc_d     = {acc_q[9:0], i_random};
                        bit_cnt_d = bit_cnt_q + 5'd8;
                    end
                    state_d = S_EMIT;
                end
                S_EMIT: begin
                    if (bit_cnt_q < 5'd11 || health) begin
                        state_d   = S_WAIT;
                        div_cnt_d = DIV_RELOAD;
                    end else if (!fifo_full) begin
                        push      = 1'b1;
                        bit_cnt_d = bit_cnt_q - 5'd11;
                        state_d   = S_WAIT;
                        div_cnt_d = DIV_RELOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FIFO pointers and fill level; full is judged before any same-cycle pop
    always_comb begin
        pop      = i_rd && !fifo_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + (AW + 1)'(1);
                2'b01:   level_d = level_q - (AW + 1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= word;
    end

    assign o_index       = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign o_valid       = !fifo_empty;
    assign o_level       = level_q;
    assign o_health_fail = health;

endmodule

// File: tb/tb_bip39_entropy_packer.sv
// Directed self-checking bench for bip39_entropy_packer (SAMPLE_DIV=1, FIFO_DEPTH=4).
module tb_bip39_entropy_packer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic [7:0]  rnd;
    logic        rd;
    logic [10:0] idx;
    logic        valid;
    logic [2:0]  level;
    logic        hfail;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned nwords;
    int unsigned w;

    bip39_entropy_packer #(.SAMPLE_DIV(1), .FIFO_DEPTH(DEPTH), .RCT_CUTOFF(8)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_flush(flush),
        .i_random(rnd), .i_rd(rd), .o_index(idx), .o_valid(valid),
        .o_level(level), .o_health_fail(hfail)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Word k of the MSB-first bit stream formed by repeating byte b
    function automatic logic [10:0] gold(input logic [7:0] b, input int unsigned k);
        logic [10:0] r = '0;
        for (int unsigned i = 0; i < 11; i++) begin
            int unsigned p = 11 * k + i;
            r = {r[9:0], b[7 - (p % 8)]};
        end
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; rnd = 8'h00; rd = 1'b0;
        #12;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_index", 32'(idx), 32'd0);
        chk("rst_health", 32'(hfail), 32'd0);
        rst_n = 1'b1;
        step(); step();

        // Two bytes A5,3C -> first word 0x529, 5 leftover bits
        rnd = 8'hA5; en = 1'b1;
        step(); step(); step();
        chk("t1_bitcnt8", 32'(dut.bit_cnt_q), 32'd8);
        rnd = 8'h3C;
        step(); step(); step();
        chk("t1_valid_early", 32'(valid), 32'd0);
        step();
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_index", 32'(idx), 32'h529);
        chk("t1_level", 32'(level), 32'd1);
        chk("t1_bitcnt5", 32'(dut.bit_cnt_q), 32'd5);

        // Byte FF -> second word 0x73F, then pop both in order
        rnd = 8'hFF;
        step(); step(); step();
        chk("t2_head", 32'(idx), 32'h529);
        chk("t2_level", 32'(level), 32'd2);
        chk("t2_bitcnt2", 32'(dut.bit_cnt_q), 32'd2);
        en = 1'b0; rd = 1'b1;
        step();
        chk("t2_pop1", 32'(idx), 32'h73F);
        chk("t2_level1", 32'(level), 32'd1);
        step();
        chk("t2_empty", 32'(valid), 32'd0);
        chk("t2_level0", 32'(level), 32'd0);
        rd = 1'b0;
        step();

        // Constant stream with no pops: level saturates at depth
        rnd = 8'hC5; en = 1'b1;
        repeat (40) step();
        chk("t3_full", 32'(level), 32'(DEPTH));
        chk("t3_head0", 32'(idx), 32'(gold(8'hC5, 0)));
        step();
        chk("t3_still_full", 32'(level), 32'(DEPTH));

        // Pop while a push is pending: push refused this cycle, lands next
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("t4_refused", 32'(level), 32'(DEPTH - 1));
        chk("t4_head1", 32'(idx), 32'(gold(8'hC5, 1)));
        step();
        chk("t4_pushed", 32'(level), 32'(DEPTH));

        // Drain and keep draining: stream must stay continuous
        for (int unsigned k = 1; k <= 6; k++) begin
            w = 0;
            while (!valid && w < 20) begin
                step();
                w++;
            end
            chk("t3_wait_valid", 32'(valid), 32'd1);
            chk("t3_word", 32'(idx), 32'(gold(8'hC5, k)));
            rd = 1'b1;
            step();
            rd = 1'b0;
        end

        // Flush wins over enable; reads on empty ignored
        flush = 1'b1;
        step();
        chk("t5_flush_level", 32'(level), 32'd0);
        chk("t5_flush_valid", 32'(valid), 32'd0);
        flush = 1'b0; en = 1'b0;
        rd = 1'b1;
        step();
        chk("t5_rd_empty", 32'(level), 32'd0);
        rd = 1'b0;

        // Disable mid-word discards the partial byte
        rnd = 8'hFF; en = 1'b1;
        step(); step(); step();
        chk("t5_bitcnt8", 32'(dut.bit_cnt_q), 32'd8);
        en = 1'b0;
        step();
        chk("t5_cleared", 32'(dut.bit_cnt_q), 32'd0);
        rnd = 8'hA5; en = 1'b1;
        step(); step(); step();
        rnd = 8'h3C;
        step(); step(); step(); step();
        chk("t5_fresh_word", 32'(idx), 32'h529);
        chk("t5_fresh_level", 32'(level), 32'd1);
        flush = 1'b1;
        step();
        chk("t5_flush2", 32'(level), 32'd0);
        flush = 1'b0; en = 1'b0;
        step();

        // All-zero stream with continuous popping
        rnd = 8'h00; rd = 1'b1; en = 1'b1;
        nwords = 0;
        for (int unsigned c = 0; c < 60; c++) begin
            if (valid) begin
                chk("t6_zero_word", 32'(idx), 32'd0);
                nwords++;
            end
            step();
        end
        rd = 1'b0;
`ifdef BIP39_RCT_EN
        chk("t6_health", 32'(hfail), 32'd1);
        chk("t6_nwords", nwords, 32'd5);
`else
        chk("t6_health", 32'(hfail), 32'd0);
        chk("t6_nwords_ge10", 32'(nwords >= 10), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
